// File: rtl/mips_pkg.sv
// Shared definitions for the MIPS debug-path pipeline controller.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
//
// Contents: controller state encoding, debug command codes, default pipeline depth.
package mips_pkg;

   // Controller states; encodings are fixed so they can be read back over debug.
   typedef enum logic [2:0] {
      ST_IDLE  = 3'd0,
      ST_RUN   = 3'd1,
      ST_STEP  = 3'd2,
      ST_DRAIN = 3'd3,
      ST_DONE  = 3'd4
   } state_e;

   // Debug unit command codes.
   localparam logic [1:0] CMD_NOP   = 2'b00;
   localparam logic [1:0] CMD_RUN   = 2'b01;
   localparam logic [1:0] CMD_STEP  = 2'b10;
   localparam logic [1:0] CMD_ABORT = 2'b11;

   // Classic 5-stage IF/ID/EX/MEM/WB pipeline.
   localparam int PIPE_DEPTH_DEFAULT = 5;

endpackage : mips_pkg

// File: rtl/sat_counter.sv
// Up-counter that sticks at all-ones instead of wrapping.
// Latency: value updates one cycle after clear/inc are sampled.
// Backpressure: none; clear has priority over inc.
//
// Ports:
//   i_clock, i_reset : clock, synchronous active-high reset (value -> 0)
//   i_clear          : zero the count on the next edge
//   i_inc            : add one on the next edge unless already saturated
//   o_value          : current count
module sat_counter #(
   parameter int WIDTH = 32
) (
   input  logic             i_clock,
   input  logic             i_reset,
   input  logic             i_clear,
   input  logic             i_inc,
   output logic [WIDTH-1:0] o_value
);

   logic [WIDTH-1:0] value_q;
   logic [WIDTH-1:0] value_d;

   always_comb begin
      value_d = value_q;
      if (i_clear) begin
         value_d = '0;
      end else if (i_inc && (value_q != '1)) begin
         value_d = value_q + WIDTH'(1);
      end
   end

   always_ff @(posedge i_clock) begin
      if (i_reset) begin
         value_q <= '0;
      end else begin
         value_q <= value_d;
      end
   end

   assign o_value = value_q;

endmodule : sat_counter

// File: rtl/pipeline_exec_controller.sv
// Debug-path run/step/abort sequencer for the 5-stage MIPS pipeline; drains after HALT in ID.
// Latency: command accepted at edge N gives the first enabled cycle at N+1; done pulses
//          PIPE_DEPTH-1 cycles after the cycle HALT is seen.
// Backpressure: o_cmd_ready low while stepping or draining; commands are otherwise taken every cycle.
//
// Ports:
//   i_clock, i_reset      : clock, synchronous active-high reset
//   i_cmd_valid/i_cmd     : debug command (NOP/RUN/STEP/ABORT), taken when o_cmd_ready
//   o_cmd_ready           : controller can accept a command this cycle
//   i_halt_decoded, i_pc  : HALT opcode in ID and its PC
//   o_pipe_enable         : global stage enable
//   o_pipe_flush          : one-cycle flush, the cycle after ABORT is taken
//   o_busy                : running, stepping or draining
//   o_done                : one-cycle pulse on entering DONE
//   o_cycle_count         : enabled cycles since last clear, saturating
//   o_halt_pc             : PC of the HALT that started the drain
module pipeline_exec_controller
   import mips_pkg::*;
#(
   parameter int NB_PC      = 32,
   parameter int NB_CYCLES  = 32,
   parameter int PIPE_DEPTH = PIPE_DEPTH_DEFAULT
) (
   input  logic                 i_clock,
   input  logic                 i_reset,
   input  logic                 i_cmd_valid,
   input  logic [1:0]           i_cmd,
   output logic                 o_cmd_ready,
   input  logic                 i_halt_decoded,
   input  logic [NB_PC-1:0]     i_pc,
   output logic                 o_pipe_enable,
   output logic                 o_pipe_flush,
   output logic                 o_busy,
   output logic                 o_done,
   output logic [NB_CYCLES-1:0] o_cycle_count,
   output logic [NB_PC-1:0]     o_halt_pc
);

   localparam int                  NB_DRAIN   = $clog2(PIPE_DEPTH);
   // HALT is in ID; the stages behind it (EX, MEM, WB) still have to retire.
   localparam logic [NB_DRAIN-1:0] DRAIN_LOAD = NB_DRAIN'(PIPE_DEPTH - 2);

   state_e              state_q, state_d;
   logic [NB_DRAIN-1:0] drain_q, drain_d;
   logic [NB_PC-1:0]    halt_pc_q, halt_pc_d;
   logic                flush_q;
   logic                done_q, done_d;
   logic                cmd_acc;
   logic                abort_acc;
   logic                cnt_clear;

   // Moore decode.
   assign o_pipe_enable = (state_q == ST_RUN) || (state_q == ST_STEP) || (state_q == ST_DRAIN);
   assign o_busy        = o_pipe_enable;
   assign o_cmd_ready   = (state_q == ST_IDLE) || (state_q == ST_RUN) || (state_q == ST_DONE);
   assign o_pipe_flush  = flush_q;
   assign o_done        = done_q;
   assign o_halt_pc     = halt_pc_q;

   assign cmd_acc   = i_cmd_valid && o_cmd_ready;
   assign abort_acc = cmd_acc && (i_cmd == CMD_ABORT);

   always_comb begin
      state_d   = state_q;
      drain_d   = drain_q;
      halt_pc_d = halt_pc_q;
      cnt_clear = 1'b0;

      unique case (state_q)
         ST_IDLE: begin
            if (cmd_acc && (i_cmd == CMD_RUN)) begin
               state_d   = ST_RUN;
               cnt_clear = 1'b1;
            end else if (cmd_acc && (i_cmd == CMD_STEP)) begin
               state_d = ST_STEP;
            end
         end
         ST_RUN: begin
            // ABORT is handled below and overrides a simultaneous HALT.
            if (!abort_acc && i_halt_decoded) begin
               state_d   = ST_DRAIN;
               halt_pc_d = i_pc;
               drain_d   = DRAIN_LOAD;
            end
         end
         ST_STEP: begin
            if (i_halt_decoded) begin
               state_d   = ST_DRAIN;
               halt_pc_d = i_pc;
               drain_d   = DRAIN_LOAD;
            end else begin
               state_d = ST_IDLE;
            end
         end
         ST_DRAIN: begin
            drain_d = drain_q - NB_DRAIN'(1);
            if (drain_q == NB_DRAIN'(1)) begin
               state_d = ST_DONE;
            end
         end
         ST_DONE: begin
            state_d = ST_DONE;
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase

      // Accepted ABORT from any ready state returns to IDLE and wipes results.
      if (abort_acc) begin
         state_d   = ST_IDLE;
         halt_pc_d = '0;
         cnt_clear = 1'b1;
      end

      done_d = (state_q == ST_DRAIN) && (state_d == ST_DONE);
   end

   always_ff @(posedge i_clock) begin
      if (i_reset) begin
         state_q   <= ST_IDLE;
         drain_q   <= '0;
         halt_pc_q <= '0;
         flush_q   <= 1'b0;
         done_q    <= 1'b0;
      end else begin
         state_q   <= state_d;
         drain_q   <= drain_d;
         halt_pc_q <= halt_pc_d;
         flush_q   <= abort_acc;
         done_q    <= done_d;
      end
   end

   sat_counter #(
      .WIDTH (NB_CYCLES)
   ) u_cycle_cnt (
      .i_clock (i_clock),
      .i_reset (i_reset),
      .i_clear (cnt_clear),
      .i_inc   (o_pipe_enable),
      .o_value (o_cycle_count)
   );

endmodule : pipeline_exec_controller

// File: tb/tb_pipeline_exec_controller.sv
module tb_pipeline_exec_controller;
   import mips_pkg::*;

   logic        clk;
   logic        i_reset;
   logic        i_cmd_valid;
   logic [1:0]  i_cmd;
   logic        i_halt_decoded;
   logic [31:0] i_pc;

   logic        o_cmd_ready, o_pipe_enable, o_pipe_flush, o_busy, o_done;
   logic [31:0] o_cycle_count, o_halt_pc;

   logic        s_cmd_ready, s_pipe_enable, s_pipe_flush, s_busy, s_done;
   logic [3:0]  s_cycle_count;
   logic [31:0] s_halt_pc;

   int n_vec;
   int n_err;

   pipeline_exec_controller #(.NB_PC(32), .NB_CYCLES(32), .PIPE_DEPTH(5)) u_dut (
      .i_clock        (clk),
      .i_reset        (i_reset),
      .i_cmd_valid    (i_cmd_valid),
      .i_cmd          (i_cmd),
      .o_cmd_ready    (o_cmd_ready),
      .i_halt_decoded (i_halt_decoded),
      .i_pc           (i_pc),
      .o_pipe_enable  (o_pipe_enable),
      .o_pipe_flush   (o_pipe_flush),
      .o_busy         (o_busy),
      .o_done         (o_done),
      .o_cycle_count  (o_cycle_count),
      .o_halt_pc      (o_halt_pc)
   );

   // Narrow-counter instance sharing the same stimulus, used for saturation.
   pipeline_exec_controller #(.NB_PC(32), .NB_CYCLES(4), .PIPE_DEPTH(5)) u_dut4 (
      .i_clock        (clk),
      .i_reset        (i_reset),
      .i_cmd_valid    (i_cmd_valid),
      .i_cmd          (i_cmd),
      .o_cmd_ready    (s_cmd_ready),
      .i_halt_decoded (i_halt_decoded),
      .i_pc           (i_pc),
      .o_pipe_enable  (s_pipe_enable),
      .o_pipe_flush   (s_pipe_flush),
      .o_busy         (s_busy),
      .o_done         (s_done),
      .o_cycle_count  (s_cycle_count),
      .o_halt_pc      (s_halt_pc)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct packed {
      logic [63:0] name;
      logic        vld;
      logic [1:0]  cmd;
      logic        halt;
      logic [31:0] pc;
      logic        en;
      logic        fl;
      logic        dn;
      logic        rdy;
      logic [31:0] cnt;
      logic [31:0] hpc;
   } vec_t;

   vec_t vecs[$];

   task automatic add(input logic [63:0] nm, input logic vld, input logic [1:0] cmd,
                      input logic halt, input logic [31:0] pc,
                      input logic en, input logic fl, input logic dn, input logic rdy,
                      input logic [31:0] cnt, input logic [31:0] hpc);
      vec_t v;
      v.name = nm; v.vld = vld; v.cmd = cmd; v.halt = halt; v.pc = pc;
      v.en = en; v.fl = fl; v.dn = dn; v.rdy = rdy; v.cnt = cnt; v.hpc = hpc;
      vecs.push_back(v);
   endtask

   // Drive one cycle's inputs at the falling edge.
   task automatic cyc(input logic vld, input logic [1:0] cmd, input logic halt,
                      input logic [31:0] pc, input logic rst);
      @(negedge clk);
      i_cmd_valid    = vld;
      i_cmd          = cmd;
      i_halt_decoded = halt;
      i_pc           = pc;
      i_reset        = rst;
   endtask

   // busy must always equal the expected enable.
   task automatic chk(input logic [63:0] nm, input logic en, input logic fl, input logic dn,
                      input logic rdy, input logic [31:0] cnt, input logic [31:0] hpc);
      n_vec++;
      if ({o_pipe_enable, o_pipe_flush, o_busy, o_done, o_cmd_ready, o_cycle_count, o_halt_pc}
          !== {en, fl, en, dn, rdy, cnt, hpc}) begin
         n_err++;
         $display("FAIL %s: got en=%b fl=%b busy=%b done=%b rdy=%b cnt=%0d hpc=%h, want en=%b fl=%b busy=%b done=%b rdy=%b cnt=%0d hpc=%h",
                  nm, o_pipe_enable, o_pipe_flush, o_busy, o_done, o_cmd_ready, o_cycle_count, o_halt_pc,
                  en, fl, en, dn, rdy, cnt, hpc);
      end
   endtask

   task automatic chk_val(input logic [63:0] nm, input logic [31:0] got, input logic [31:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0d, want %0d", nm, got, exp);
      end
   endtask

   initial begin
      n_vec = 0;
      n_err = 0;
      i_reset = 1'b1; i_cmd_valid = 1'b0; i_cmd = CMD_NOP; i_halt_decoded = 1'b0; i_pc = '0;

      //   name        vld cmd       halt pc        en fl dn rdy cnt  hpc
      add("reset",      0, CMD_NOP,   0, 32'h0,     0, 0, 0, 1, 0,  32'h0);
      // RUN with HALT on the 10th enabled cycle.
      add("run_cmd",    1, CMD_RUN,   0, 32'h0,     0, 0, 0, 1, 0,  32'h0);
      for (int j = 0; j < 9; j++)
         add("run",     0, CMD_NOP,   0, 32'h0,     1, 0, 0, 1, j,  32'h0);
      add("halt_id",    0, CMD_NOP,   1, 32'h24,    1, 0, 0, 1, 9,  32'h0);
      add("drain1",     0, CMD_NOP,   1, 32'h30,    1, 0, 0, 0, 10, 32'h24);
      add("drain2",     0, CMD_NOP,   0, 32'h0,     1, 0, 0, 0, 11, 32'h24);
      add("drain3",     0, CMD_NOP,   0, 32'h0,     1, 0, 0, 0, 12, 32'h24);
      add("done",       1, CMD_RUN,   0, 32'h0,     0, 0, 1, 1, 13, 32'h24);
      add("done_hld",   1, CMD_STEP,  0, 32'h0,     0, 0, 0, 1, 13, 32'h24);
      add("done_hl2",   0, CMD_NOP,   1, 32'h50,    0, 0, 0, 1, 13, 32'h24);
      add("abort_dn",   1, CMD_ABORT, 0, 32'h0,     0, 0, 0, 1, 13, 32'h24);
      add("flush_dn",   0, CMD_NOP,   0, 32'h0,     0, 1, 0, 1, 0,  32'h0);
      add("idle",       0, CMD_NOP,   0, 32'h0,     0, 0, 0, 1, 0,  32'h0);
      // Three single steps; an ABORT offered while stepping is not taken.
      add("step1",      1, CMD_STEP,  0, 32'h0,     0, 0, 0, 1, 0,  32'h0);
      add("step1_en",   1, CMD_ABORT, 0, 32'h0,     1, 0, 0, 0, 0,  32'h0);
      add("step2",      1, CMD_STEP,  0, 32'h0,     0, 0, 0, 1, 1,  32'h0);
      add("step2_en",   0, CMD_NOP,   0, 32'h0,     1, 0, 0, 0, 1,  32'h0);
      add("step3",      1, CMD_STEP,  0, 32'h0,     0, 0, 0, 1, 2,  32'h0);
      add("step3_en",   0, CMD_NOP,   0, 32'h0,     1, 0, 0, 0, 2,  32'h0);
      add("step_end",   1, CMD_ABORT, 0, 32'h0,     0, 0, 0, 1, 3,  32'h0);
      add("flush_st",   0, CMD_NOP,   0, 32'h0,     0, 1, 0, 1, 0,  32'h0);
      // STEP that lands on HALT drains and completes.
      add("stph_cmd",   1, CMD_STEP,  0, 32'h0,     0, 0, 0, 1, 0,  32'h0);
      add("stph_en",    0, CMD_NOP,   1, 32'h40,    1, 0, 0, 0, 0,  32'h0);
      add("stph_dr1",   0, CMD_NOP,   0, 32'h0,     1, 0, 0, 0, 1,  32'h40);
      add("stph_dr2",   0, CMD_NOP,   0, 32'h0,     1, 0, 0, 0, 2,  32'h40);
      add("stph_dr3",   0, CMD_NOP,   0, 32'h0,     1, 0, 0, 0, 3,  32'h40);
      add("stph_dn",    0, CMD_NOP,   0, 32'h0,     0, 0, 1, 1, 4,  32'h40);
      add("stph_ab",    1, CMD_ABORT, 0, 32'h0,     0, 0, 0, 1, 4,  32'h40);
      add("stph_fl",    0, CMD_NOP,   0, 32'h0,     0, 1, 0, 1, 0,  32'h0);
      // ABORT in the same RUN cycle as HALT.
      add("ab_run",     1, CMD_RUN,   0, 32'h0,     0, 0, 0, 1, 0,  32'h0);
      add("ab_r1",      0, CMD_NOP,   0, 32'h0,     1, 0, 0, 1, 0,  32'h0);
      add("ab_r2",      0, CMD_NOP,   0, 32'h0,     1, 0, 0, 1, 1,  32'h0);
      add("ab_halt",    1, CMD_ABORT, 1, 32'h88,    1, 0, 0, 1, 2,  32'h0);
      add("ab_flush",   0, CMD_NOP,   0, 32'h0,     0, 1, 0, 1, 0,  32'h0);
      // HALT while idle is not sampled; ABORT from idle still flushes.
      add("idle_hlt",   0, CMD_NOP,   1, 32'h90,    0, 0, 0, 1, 0,  32'h0);
      add("idle_ab",    1, CMD_ABORT, 0, 32'h0,     0, 0, 0, 1, 0,  32'h0);
      add("idle_fl",    0, CMD_NOP,   0, 32'h0,     0, 1, 0, 1, 0,  32'h0);
      add("idle_end",   0, CMD_NOP,   0, 32'h0,     0, 0, 0, 1, 0,  32'h0);

      repeat (3) @(negedge clk);
      i_reset = 1'b0;

      for (int i = 0; i < vecs.size(); i++) begin
         cyc(vecs[i].vld, vecs[i].cmd, vecs[i].halt, vecs[i].pc, 1'b0);
         chk(vecs[i].name, vecs[i].en, vecs[i].fl, vecs[i].dn, vecs[i].rdy, vecs[i].cnt, vecs[i].hpc);
      end

      // Reset during the second drain cycle.
      cyc(1'b1, CMD_RUN, 1'b0, 32'h0, 1'b0);
      cyc(1'b0, CMD_NOP, 1'b1, 32'h99, 1'b0);
      chk("rst_run", 1'b1, 1'b0, 1'b0, 1'b1, 32'd0, 32'h0);
      cyc(1'b0, CMD_NOP, 1'b0, 32'h0, 1'b0);
      chk("rst_dr1", 1'b1, 1'b0, 1'b0, 1'b0, 32'd1, 32'h99);
      cyc(1'b0, CMD_NOP, 1'b0, 32'h0, 1'b1);
      chk("rst_dr2", 1'b1, 1'b0, 1'b0, 1'b0, 32'd2, 32'h99);
      for (int k = 0; k < 4; k++) begin
         cyc(1'b0, CMD_NOP, 1'b0, 32'h0, 1'b0);
         chk("rst_aft", 1'b0, 1'b0, 1'b0, 1'b1, 32'd0, 32'h0);
      end

      // Saturation: 4-bit counter sticks at 15, 32-bit one keeps counting.
      cyc(1'b1, CMD_RUN, 1'b0, 32'h0, 1'b0);
      for (int j = 0; j <= 20; j++) begin
         cyc(1'b0, CMD_NOP, 1'b0, 32'h0, 1'b0);
         if (j == 4)  chk_val("sat_c4",  {28'h0, s_cycle_count}, 32'd4);
         if (j == 15) chk_val("sat_c15", {28'h0, s_cycle_count}, 32'd15);
         if (j == 16) chk_val("sat_c16", {28'h0, s_cycle_count}, 32'd15);
         if (j == 20) begin
            chk_val("sat_c20", {28'h0, s_cycle_count}, 32'd15);
            chk_val("wide_c20", o_cycle_count, 32'd20);
         end
      end
      cyc(1'b1, CMD_ABORT, 1'b0, 32'h0, 1'b0);
      cyc(1'b0, CMD_NOP, 1'b0, 32'h0, 1'b0);
      chk_val("sat_clr", {28'h0, s_cycle_count}, 32'd0);
      chk("sat_abfl", 1'b0, 1'b1, 1'b0, 1'b1, 32'd0, 32'h0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule : tb_pipeline_exec_controller
